stage_mem: RTL

Memory stage of the lc3b pipeline. It sits directly downstream of the execute stage and consumes that stage's ALU result (the effective address) and forwarded store data through the EX/MEM pipeline register. It runs data-memory handshakes for LDR/STR, LDB/STB and LDI/STI. LDI/STI use a two-access indirect state machine. The stage stalls the pipeline until its access completes and hands load data to writeback.

---
 rtl/stage_mem_pkg.sv | 21 ++
 rtl/stage_mem_if.sv | 23 ++
 rtl/mem_format.sv | 26 ++
 rtl/stage_mem.sv | 150 +++++++++++++++
 4 files changed

// File: rtl/stage_mem_pkg.sv
// Shared lc3b types for the memory stage: word, control word fields and FSM states.
// The optional LDI/STI double access is enabled by the STAGE_MEM_INDIRECT_EN macro.
package stage_mem_pkg;

  typedef logic [15:0] lc3b_word;

  typedef struct packed {
    logic mem_read;
    logic mem_write;
    logic mem_byte;
    logic mem_indirect;
  } lc3b_control_word;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCESS1 = 2'd1,
    ACCESS2 = 2'd2,
    DONE    = 2'd3
  } lc3b_mem_state;

endpackage

// File: rtl/stage_mem_if.sv
// Data-memory request/response bus between the memory stage (master) and data memory (slave).
// Handshake: a strobe (dmem_read or dmem_write) is held with stable address/wdata/byte_enable until a one-cycle dmem_resp.
interface stage_mem_if;
  import stage_mem_pkg::*;

  lc3b_word   dmem_address;
  logic       dmem_read;
  logic       dmem_write;
  logic [1:0] dmem_byte_enable;
  lc3b_word   dmem_wdata;
  lc3b_word   dmem_rdata;
  logic       dmem_resp;

  modport master (
    output dmem_address, dmem_read, dmem_write, dmem_byte_enable, dmem_wdata,
    input  dmem_rdata, dmem_resp
  );

  modport slave (
    input  dmem_address, dmem_read, dmem_write, dmem_byte_enable, dmem_wdata,
    output dmem_rdata, dmem_resp
  );
endinterface

// File: rtl/mem_format.sv
// Combinational lane formatting: store byte-enable and byte replication, LDB sign extension.
module mem_format
  import stage_mem_pkg::*;
(
  input  logic       byte_op_i,
  input  logic       addr_lsb_i,
  input  lc3b_word   wdata_src_i,
  input  lc3b_word   rdata_i,
  output logic [1:0] byte_enable_o,
  output lc3b_word   wdata_o,
  output lc3b_word   rdata_fmt_o
);
  logic [7:0] rd_byte;

  always_comb begin
    byte_enable_o = 2'b11;
    wdata_o       = wdata_src_i;
    rdata_fmt_o   = rdata_i;
    rd_byte       = addr_lsb_i ? rdata_i[15:8] : rdata_i[7:0];
    if (byte_op_i) begin
      byte_enable_o = addr_lsb_i ? 2'b10 : 2'b01;
      wdata_o       = {wdata_src_i[7:0], wdata_src_i[7:0]};
      rdata_fmt_o   = {{8{rd_byte[7]}}, rd_byte};
    end
  end
endmodule

// File: rtl/stage_mem.sv
// lc3b memory stage: runs LDR/STR, LDB/STB (and LDI/STI when STAGE_MEM_INDIRECT_EN is defined)
// against data memory, stalling the pipeline until the access completes.
module stage_mem
  import stage_mem_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             valid_in,
  input  lc3b_control_word control_in,
  input  lc3b_word         alu_in,
  input  lc3b_word         sr2_in,
  input  logic             stall_in,
  stage_mem_if.master      dmem,
  output lc3b_word         mem_data_out,
  output logic             stall_out,
  output lc3b_mem_state    state_dbg_o
);
  lc3b_mem_state state_q, state_d;
  lc3b_word      data_q, data_d;
`ifdef STAGE_MEM_INDIRECT_EN
  logic [15:1]   ptr_q, ptr_d;
`endif

  logic       is_mem, is_store, ind, byte_op;
  logic [1:0] fmt_be;
  lc3b_word   fmt_wdata, fmt_rdata;
  logic       rd_c, wr_c, stall_c;
  logic [1:0] be_c;
  lc3b_word   addr_c, wdata_c, out_c;

  assign is_mem   = valid_in & (control_in.mem_read | control_in.mem_write);
  assign is_store = control_in.mem_write;
  // Indirect ops always start with a word pointer fetch, so they never take the byte path.
  assign byte_op  = control_in.mem_byte & ~control_in.mem_indirect;
`ifdef STAGE_MEM_INDIRECT_EN
  assign ind = control_in.mem_indirect;
`else
  assign ind = 1'b0;
`endif

  mem_format u_fmt (
    .byte_op_i    (byte_op),
    .addr_lsb_i   (alu_in[0]),
    .wdata_src_i  (sr2_in),
    .rdata_i      (dmem.dmem_rdata),
    .byte_enable_o(fmt_be),
    .wdata_o      (fmt_wdata),
    .rdata_fmt_o  (fmt_rdata)
  );

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
`ifdef STAGE_MEM_INDIRECT_EN
    ptr_d   = ptr_q;
`endif
    rd_c    = 1'b0;
    wr_c    = 1'b0;
    stall_c = 1'b0;
    addr_c  = byte_op ? alu_in : {alu_in[15:1], 1'b0};
    be_c    = fmt_be;
    wdata_c = fmt_wdata;
    out_c   = fmt_rdata;
    case (state_q)
      IDLE, ACCESS1: begin
        if (is_mem) begin
          rd_c = ind | ~is_store;
          wr_c = ~ind & is_store;
          if (dmem.dmem_resp) begin
`ifdef STAGE_MEM_INDIRECT_EN
            // The pointer fetch completing is not the end of the instruction: keep upstream held.
            if (ind) begin
              ptr_d   = dmem.dmem_rdata[15:1];
              state_d = ACCESS2;
              stall_c = 1'b1;
            end else
`endif
            if (stall_in) begin
              data_d  = fmt_rdata;
              state_d = DONE;
            end else begin
              state_d = IDLE;
            end
          end else begin
            stall_c = 1'b1;
            state_d = ACCESS1;
          end
        end else begin
          state_d = IDLE;
        end
      end
`ifdef STAGE_MEM_INDIRECT_EN
      ACCESS2: begin
        rd_c    = ~is_store;
        wr_c    = is_store;
        addr_c  = {ptr_q, 1'b0};
        be_c    = 2'b11;
        wdata_c = sr2_in;
        if (dmem.dmem_resp) begin
          if (stall_in) begin
            data_d  = fmt_rdata;
            state_d = DONE;
          end else begin
            state_d = IDLE;
          end
        end else begin
          stall_c = 1'b1;
        end
      end
`endif
      DONE: begin
        out_c = data_q;
        if (!stall_in) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // Reset abandons any request immediately, without waiting for the clock.
    if (reset) begin
      rd_c    = 1'b0;
      wr_c    = 1'b0;
      stall_c = 1'b0;
      out_c   = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      data_q  <= '0;
`ifdef STAGE_MEM_INDIRECT_EN
      ptr_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
`ifdef STAGE_MEM_INDIRECT_EN
      ptr_q   <= ptr_d;
`endif
    end
  end

  assign dmem.dmem_address     = addr_c;
  assign dmem.dmem_read        = rd_c;
  assign dmem.dmem_write       = wr_c;
  assign dmem.dmem_byte_enable = be_c;
  assign dmem.dmem_wdata       = wdata_c;
  assign mem_data_out          = out_c;
  assign stall_out             = stall_c;
  assign state_dbg_o           = state_q;
endmodule
